store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buf_pkg.sv | 22 ++
 rtl/store_buf_fifo.sv | 63 ++++++
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared types and constants for the store buffer: drain-state enum and queued entry payload.
package store_buf_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT  = 4;
    localparam int unsigned SB_ADDR_W_DEFAULT = 32;
    // Entry address field width; the top's ADDR_W must not exceed this.
    localparam int unsigned SB_ADDR_W         = 32;
    localparam int unsigned SB_DATA_W         = 32;
    localparam int unsigned SB_BE_W           = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_BE_W-1:0]   byteen;
    } sb_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Circular entry storage for the store buffer; exposes head, per-slot word addresses and occupancy.
module store_buf_fifo
    import store_buf_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  sb_entry_t                 i_entry,
    output sb_entry_t                 o_head,
    output logic [SB_ADDR_W-3:0]      o_word_addr [DEPTH],
    output logic [DEPTH-1:0]          o_valid,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid[i]     = CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count;
            o_word_addr[i] = r_mem[i].addr[SB_ADDR_W-1:2];
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/store_buffer.sv
// Post-M-stage store buffer: queues committed stores, drains them to the bus, flags load hazards.
// Optional STORE_BUF_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = SB_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Req,
    input  logic                   st_valid,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [31:0]            st_data,
    input  logic [3:0]             st_byteen,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   stall,
    output logic                   bus_req,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_byteen,
    input  logic                   bus_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
`ifdef STORE_BUF_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned WA_W  = SB_ADDR_W - 2;

    drain_state_e        r_state;
    drain_state_e        w_state_next;
    sb_entry_t           w_entry;
    sb_entry_t           w_head;
    logic [WA_W-1:0]     w_word_addr [DEPTH];
    logic [DEPTH-1:0]    w_valid;
    logic [CNT_W-1:0]    w_count;
    logic                w_full;
    logic                w_st_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_ld_hit;
    logic [WA_W-1:0]     w_ld_word;
    logic                w_addr_lo_unused;

    assign w_full  = (w_count == CNT_W'(DEPTH));
    assign w_st_ok = st_valid & (|st_byteen) & ~Req;
    assign w_push  = w_st_ok & ~w_full;
    assign w_pop   = (r_state == WAIT) & bus_ack;
    assign w_entry = '{addr: SB_ADDR_W'(st_addr), data: st_data, byteen: st_byteen};

    store_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_entry     (w_entry),
        .o_head      (w_head),
        .o_word_addr (w_word_addr),
        .o_valid     (w_valid),
        .o_count     (w_count)
    );

    // Word-granular hazard compare; includes the head even while it is being popped.
    assign w_ld_word = WA_W'(ld_addr[ADDR_W-1:2]);
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_word_addr[i] == w_ld_word)) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    assign stall = (w_st_ok & w_full) | (ld_valid & w_ld_hit);
    assign w_addr_lo_unused = ^{w_head.addr[1:0], ld_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_count != '0) w_state_next = WAIT;
            WAIT: if (bus_ack && (w_count == CNT_W'(1)) && !w_push) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign bus_req    = (r_state == WAIT);
    assign bus_addr   = bus_req ? ADDR_W'({w_head.addr[SB_ADDR_W-1:2], 2'b00}) : '0;
    assign bus_wdata  = bus_req ? w_head.data : '0;
    assign bus_byteen = bus_req ? w_head.byteen : '0;
    assign count      = w_count;
    assign empty      = (w_count == '0);

`ifdef STORE_BUF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              Req;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_byteen;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              stall;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_byteen;
    logic              bus_ack;
    logic [2:0]        count;
    logic              empty;
`ifdef STORE_BUF_STALL_CNT_EN
    logic [31:0]       stall_cnt;
    longint            m_stall_cnt;
`endif

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_byteen  (st_byteen),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen),
        .bus_ack    (bus_ack),
        .count      (count),
        .empty      (empty)
`ifdef STORE_BUF_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   prev_size;
    int   n_assert;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] sb, input logic rq, input logic lv,
                        input logic [31:0] la, input logic ack);
        logic exp_req;
        logic exp_stall;
        logic hit;
        logic push;
        logic pop;
        ent_t e;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; st_byteen = sb;
        Req = rq; ld_valid = lv; ld_addr = la; bus_ack = ack;
        #1;
        // A write is on the bus iff the queue was non-empty last cycle and still is now.
        exp_req = (prev_size > 0) && (q.size() > 0);
        hit = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) hit = 1'b1;
        exp_stall = (sv && (sb != 4'b0) && !rq && (q.size() == DEPTH)) || (lv && hit);
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("bus_req", 64'(bus_req), 64'(exp_req));
        chk("stall", 64'(stall), 64'(exp_stall));
        if (exp_req) begin
            chk("bus_addr", 64'(bus_addr), 64'({q[0].addr[31:2], 2'b00}));
            chk("bus_wdata", 64'(bus_wdata), 64'(q[0].data));
            chk("bus_byteen", 64'(bus_byteen), 64'(q[0].be));
        end
`ifdef STORE_BUF_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        if (exp_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
`endif
        push = sv && (sb != 4'b0) && !rq && (q.size() < DEPTH);
        pop  = exp_req && ack;
        prev_size = q.size();
        if (pop) void'(q.pop_front());
        if (push) begin
            e.addr = sa; e.data = sd; e.be = sb;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, ack);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic ack);
        step(1'b1, a, d, b, 1'b0, 1'b0, 32'h0, ack);
    endtask

    task automatic load(input logic [31:0] a, input logic ack);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, a, ack);
    endtask

    // Asynchronous reset applied mid-cycle, held across one rising edge.
    task automatic do_reset();
        @(negedge clk);
        st_valid = 1'b0; st_byteen = 4'h0; Req = 1'b0; ld_valid = 1'b0; bus_ack = 1'b0;
        reset = 1'b1;
        #1;
        q.delete();
        prev_size = 0;
`ifdef STORE_BUF_STALL_CNT_EN
        m_stall_cnt = 0;
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_bus_byteen", 64'(bus_byteen), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; prev_size = 0;
        reset = 1'b1; Req = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        st_byteen = '0; ld_valid = 1'b0; ld_addr = '0; bus_ack = 1'b0;
`ifdef STORE_BUF_STALL_CNT_EN
        m_stall_cnt = 0;
`endif
        repeat (2) @(posedge clk);
        do_reset();

        // Single word store, acked two cycles after it is presented.
        store(32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        idle(1'b0);
        idle(1'b1);
        chk("sw_bus_addr", 64'(bus_addr), 64'h1004);
        chk("sw_bus_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
        idle(1'b0);
        chk("sw_empty", 64'(empty), 64'd1);

        // Five stores with no ack: fifth stalls and is retried while the queue drains.
        do_reset();
        for (int k = 0; k < 5; k++) store(32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_stall", 64'(stall), 64'd1);
        store(32'h110, 32'hA000_0004, 4'hF, 1'b1);
        store(32'h110, 32'hA000_0004, 4'hF, 1'b1);
        for (int k = 0; k < 6; k++) idle(1'b1);

        // Byte store hazard against loads to the same and to a neighbouring word.
        do_reset();
        store(32'h2003, 32'hAA00_0000, 4'b1000, 1'b0);
        load(32'h2000, 1'b0);
        chk("ld_hit_stall", 64'(stall), 64'd1);
        load(32'h2000, 1'b0);
        load(32'h2004, 1'b0);
        chk("ld_miss_stall", 64'(stall), 64'd0);
        load(32'h2000, 1'b1);
        load(32'h2000, 1'b0);
        chk("ld_after_pop", 64'(stall), 64'd0);

        // Killed and empty-byteen stores, including while the queue is full.
        step(1'b1, 32'h3000, 32'h1, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h3000, 32'h1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("discard_count", 64'(count), 64'd0);
        for (int k = 0; k < 4; k++) store(32'h3000 + 32'(k * 4), 32'(k), 4'h3, 1'b0);
        step(1'b1, 32'h3100, 32'h9, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("req_full_stall", 64'(stall), 64'd0);
        step(1'b1, 32'h3100, 32'h9, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while draining with three entries; a late ack must be ignored.
        do_reset();
        for (int k = 0; k < 3; k++) store(32'h4000 + 32'(k * 4), 32'hB0 + 32'(k), 4'hF, 1'b0);
        idle(1'b0);
        chk("pre_rst_req", 64'(bus_req), 64'd1);
        do_reset();
        idle(1'b1);
        idle(1'b1);
        chk("late_ack_count", 64'(count), 64'd0);

`ifdef STORE_BUF_STALL_CNT_EN
        do_reset();
        for (int k = 0; k < 4; k++) store(32'h5000 + 32'(k * 4), 32'(k), 4'hF, 1'b0);
        for (int k = 0; k < 7; k++) store(32'h5100, 32'h77, 4'hF, 1'b0);
        idle(1'b0);
        chk("stall_cnt_7", 64'(stall_cnt), 64'd7);
        do_reset();
`endif

        // Random traffic over a small address window to provoke hazards and full stalls.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 32'h6000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                 $urandom,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 32'h6000 + 32'($urandom_range(0, 9) * 4),
                 1'($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < 8; k++) idle(1'b1);
        chk("final_empty", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
